// File: rtl/tdp_ram_pipe.sv
// Single-clock true dual-port RAM with per-port write-commit and read-latency pipelines.
// Define TDP_RAM_PARITY_EN to store and recheck one even-parity bit per byte.
module tdp_ram_pipe #(
   parameter int ADDR_WIDTH    = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int READ_LATENCY  = 3,
   parameter int WRITE_LATENCY = 3,
   parameter int RD_MODE       = 0
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_ena,
   input  logic                    i_wea,
   input  logic [DATA_WIDTH/8-1:0] i_bea,
   input  logic [ADDR_WIDTH-1:0]   i_addra,
   input  logic [DATA_WIDTH-1:0]   i_dina,
   output logic [DATA_WIDTH-1:0]   o_douta,
   output logic                    o_valida,
   input  logic                    i_enb,
   input  logic                    i_web,
   input  logic [DATA_WIDTH/8-1:0] i_beb,
   input  logic [ADDR_WIDTH-1:0]   i_addrb,
   input  logic [DATA_WIDTH-1:0]   i_dinb,
   output logic [DATA_WIDTH-1:0]   o_doutb,
   output logic                    o_validb,
`ifdef TDP_RAM_PARITY_EN
   input  logic                    i_perr_inj,
   output logic [DATA_WIDTH/8-1:0] o_perra,
   output logic [DATA_WIDTH/8-1:0] o_perrb,
`endif
   output logic                    o_collision
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int RL    = READ_LATENCY;
   localparam int WL    = WRITE_LATENCY;

   if ((DATA_WIDTH % 8) != 0 || RL < 1 || RL > 8 || WL < 1 || WL > 8) begin : g_cfg_check
      $fatal(1, "tdp_ram_pipe: DATA_WIDTH must be a multiple of 8 and latencies within 1..8");
   end

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [NB-1:0]         be;
      logic [DATA_WIDTH-1:0] data;
   } wr_req_t;

   // index 0 is port A, index 1 is port B
   logic    [1:0]                     en, we;
   wr_req_t [1:0]                     req;
   wr_req_t [1:0][WL:1]               wr_pipe_q, wr_pipe_d;
   logic    [1:0][WL:1]               wvld_pipe_q, wvld_pipe_d;
   wr_req_t [1:0]                     cw;
   logic    [1:0]                     cmt;
   logic    [1:0][RL:1]               rvld_pipe_q, rvld_pipe_d;
   logic    [1:0][RL:1][DATA_WIDTH-1:0] rdat_pipe_q, rdat_pipe_d;
   logic    [1:0][DATA_WIDTH-1:0]     rd_word, dout_q, dout_d;
   logic    [1:0]                     valid_q, valid_d;
   logic                              coll_q, coll_d;
   logic    [DATA_WIDTH-1:0]          mem_q [DEPTH];

   assign en     = {i_enb, i_ena};
   assign we     = {i_web, i_wea};
   assign req[0] = '{addr: i_addra, be: i_bea, data: i_dina};
   assign req[1] = '{addr: i_addrb, be: i_beb, data: i_dinb};

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         cw[p]  = wr_pipe_q[p][WL];
         cmt[p] = wvld_pipe_q[p][WL];
      end
   end

   // Read sample on the acceptance edge; WRITE_FIRST folds in same-edge commits, A last.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_word[p] = mem_q[req[p].addr];
         if (RD_MODE != 0) begin
            for (int q = 1; q >= 0; q--) begin
               if (cmt[q] && cw[q].addr == req[p].addr) begin
                  for (int k = 0; k < NB; k++) begin
                     if (cw[q].be[k]) rd_word[p][8*k +: 8] = cw[q].data[8*k +: 8];
                  end
               end
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         wvld_pipe_d[p][1] = en[p] & we[p];
         wr_pipe_d[p][1]   = req[p];
         for (int s = 2; s <= WL; s++) begin
            wvld_pipe_d[p][s] = wvld_pipe_q[p][s-1];
            wr_pipe_d[p][s]   = wr_pipe_q[p][s-1];
         end
         rvld_pipe_d[p][1] = en[p] & ~we[p];
         rdat_pipe_d[p][1] = rd_word[p];
         for (int s = 2; s <= RL; s++) begin
            rvld_pipe_d[p][s] = rvld_pipe_q[p][s-1];
            rdat_pipe_d[p][s] = rdat_pipe_q[p][s-1];
         end
         valid_d[p] = rvld_pipe_q[p][RL];
         dout_d[p]  = rvld_pipe_q[p][RL] ? rdat_pipe_q[p][RL] : dout_q[p];
      end
      coll_d = cmt[0] & cmt[1] & (cw[0].addr == cw[1].addr) & (|(cw[0].be & cw[1].be));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wvld_pipe_q <= '0;
         wr_pipe_q   <= '0;
         rvld_pipe_q <= '0;
         rdat_pipe_q <= '0;
         dout_q      <= '0;
         valid_q     <= '0;
         coll_q      <= 1'b0;
      end else begin
         wvld_pipe_q <= wvld_pipe_d;
         wr_pipe_q   <= wr_pipe_d;
         rvld_pipe_q <= rvld_pipe_d;
         rdat_pipe_q <= rdat_pipe_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
         coll_q      <= coll_d;
      end
   end

   // B is applied before A so A wins on overlapping bytes; contents are never reset.
   always_ff @(posedge i_clk) begin
      for (int q = 1; q >= 0; q--) begin
         if (cmt[q]) begin
            for (int k = 0; k < NB; k++) begin
               if (cw[q].be[k]) mem_q[cw[q].addr][8*k +: 8] <= cw[q].data[8*k +: 8];
            end
         end
      end
   end

   assign o_douta     = dout_q[0];
   assign o_doutb     = dout_q[1];
   assign o_valida    = valid_q[0];
   assign o_validb    = valid_q[1];
   assign o_collision = coll_q;

`ifdef TDP_RAM_PARITY_EN
   logic [1:0][NB-1:0]       wpar, rd_par, rd_err, perr_q, perr_d;
   logic [1:0][RL:1][NB-1:0] rerr_pipe_q, rerr_pipe_d;
   logic [NB-1:0]            par_q [DEPTH];

   always_comb begin
      for (int q = 0; q < 2; q++) begin
         for (int k = 0; k < NB; k++) begin
            wpar[q][k] = (^cw[q].data[8*k +: 8]) ^ ((k == 0) & i_perr_inj);
         end
      end
      for (int p = 0; p < 2; p++) begin
         rd_par[p] = par_q[req[p].addr];
         if (RD_MODE != 0) begin
            for (int q = 1; q >= 0; q--) begin
               if (cmt[q] && cw[q].addr == req[p].addr) begin
                  for (int k = 0; k < NB; k++) begin
                     if (cw[q].be[k]) rd_par[p][k] = wpar[q][k];
                  end
               end
            end
         end
         for (int k = 0; k < NB; k++) rd_err[p][k] = rd_par[p][k] ^ (^rd_word[p][8*k +: 8]);
         rerr_pipe_d[p][1] = rd_err[p];
         for (int s = 2; s <= RL; s++) rerr_pipe_d[p][s] = rerr_pipe_q[p][s-1];
         perr_d[p] = rvld_pipe_q[p][RL] ? rerr_pipe_q[p][RL] : perr_q[p];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rerr_pipe_q <= '0;
         perr_q      <= '0;
      end else begin
         rerr_pipe_q <= rerr_pipe_d;
         perr_q      <= perr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      for (int q = 1; q >= 0; q--) begin
         if (cmt[q]) begin
            for (int k = 0; k < NB; k++) begin
               if (cw[q].be[k]) par_q[cw[q].addr][k] <= wpar[q][k];
            end
         end
      end
   end

   assign o_perra = perr_q[0];
   assign o_perrb = perr_q[1];
`endif
endmodule
